mem_copy_engine: RTL and testbench

- Avalon-MM master that sits directly upstream of the 16K x 32 on-chip RAM. It drives the RAM's address, byteenable, chipselect, clken, write and writedata, and consumes its readdata.
- The CPU programs source, destination and length through a small CSR slave. The engine then copies LEN 32-bit words inside the RAM without processor involvement.
- The master port is point-to-point to the RAM. It has no waitrequest, and the RAM read latency is fixed at 1 cycle.

---
 rtl/mem_copy_engine.sv | 205 ++++++++++++++++++++
 tb/tb_mem_copy_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: CSR-programmed word copier acting as an Avalon-MM master
// in front of a 1-cycle-latency on-chip RAM. Copy runs RD -> CAP -> WR per
// word (3 cycles/word). Optional fill mode is compiled in with the macro
// MEM_COPY_FILL_EN; without it only copy mode exists, and the FILL register
// and the mode bit read back as 0.
module mem_copy_engine #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    output logic              m_clken,
    output logic              irq
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, dst_q;
    logic [LEN_W-1:0]    len_q;
    logic [ADDR_W-1:0]   sptr_q, sptr_d, dptr_q, dptr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, done_q, ie_q;
    logic [31:0]         fill_q;
    logic                mode_q;
    logic                fill_sel;
    logic                fill_now;

    logic                csr_we, ctrl_we, go;
    logic                cs_d, wr_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [31:0]         wdata_d;

    // bits of the CSR write data that no register consumes
    logic                unused_wdata;
    assign unused_wdata = ^csr_writedata;

    assign csr_we  = csr_chipselect & csr_write;
    assign ctrl_we = csr_we && (csr_address == 3'd3);
    // go is only honoured from IDLE; busy is high for every non-IDLE state
    assign go      = ctrl_we && csr_writedata[0] && !busy_q;

    assign m_clken      = 1'b1;
    assign m_byteenable = m_chipselect ? 4'hF : 4'h0;
    assign irq          = done_q & ie_q;

`ifdef MEM_COPY_FILL_EN
    assign fill_sel = csr_writedata[2];

    // FILL pattern and mode bit; frozen while a transfer is in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q <= '0;
            mode_q <= 1'b0;
        end else if (csr_we && !busy_q) begin
            if (csr_address == 3'd4) fill_q <= csr_writedata;
            if (csr_address == 3'd3) mode_q <= csr_writedata[2];
        end
    end
`else
    assign fill_sel = 1'b0;
    assign fill_q   = '0;
    assign mode_q   = 1'b0;
`endif

    // On the go edge mode_q is not yet updated, so take it from the write data
    assign fill_now = (state_q == IDLE) ? fill_sel : mode_q;

    // Programming registers; frozen while a transfer is in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
        end else if (csr_we && !busy_q) begin
            case (csr_address)
                3'd0:    src_q <= csr_writedata[ADDR_W-1:0];
                3'd1:    dst_q <= csr_writedata[ADDR_W-1:0];
                3'd2:    len_q <= csr_writedata[LEN_W-1:0];
                default: ;
            endcase
        end
    end

    // Status flags: go beats a simultaneous done-clear, FIN sets done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ie_q   <= 1'b0;
        end else begin
            if (ctrl_we) ie_q <= csr_writedata[3];
            if (go) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end else if (state_q == FIN) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else if (ctrl_we && csr_writedata[1]) begin
                done_q <= 1'b0;
            end
        end
    end

    // CSR read mux, purely combinational from csr_address
    always_comb begin
        csr_readdata = '0;
        case (csr_address)
            3'd0:    csr_readdata = 32'(src_q);
            3'd1:    csr_readdata = 32'(dst_q);
            3'd2:    csr_readdata = 32'(len_q);
            3'd3:    csr_readdata = {28'b0, ie_q, mode_q, done_q, busy_q};
            3'd4:    csr_readdata = fill_q;
            default: csr_readdata = '0;
        endcase
    end

    // Next state and working counters
    always_comb begin
        state_d = state_q;
        sptr_d  = sptr_q;
        dptr_d  = dptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    sptr_d = src_q;
                    dptr_d = dst_q;
                    cnt_d  = len_q;
                    if (len_q == '0)   state_d = FIN;
                    else if (fill_sel) state_d = WR;
                    else               state_d = RD;
                end
            end
            RD:  state_d = CAP;
            CAP: state_d = WR;
            WR: begin
                sptr_d = sptr_q + ADDR_W'(1);
                dptr_d = dptr_q + ADDR_W'(1);
                cnt_d  = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) state_d = FIN;
                else if (mode_q)        state_d = WR;
                else                    state_d = RD;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Master outputs are decoded from the next state so they can be registered
    always_comb begin
        cs_d    = (state_d == RD) || (state_d == WR);
        wr_d    = (state_d == WR);
        addr_d  = '0;
        wdata_d = '0;
        if (state_d == RD) addr_d = sptr_d;
        if (state_d == WR) begin
            addr_d  = dptr_d;
            // leaving CAP, m_readdata holds the word read in RD
            wdata_d = fill_now ? fill_q : m_readdata;
        end
    end

    // State register and working counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sptr_q  <= '0;
            dptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sptr_q  <= sptr_d;
            dptr_q  <= dptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered master port; m_writedata doubles as the captured data word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
        end else begin
            m_chipselect <= cs_d;
            m_write      <= wr_d;
            m_address    <= addr_d;
            m_writedata  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: stimulus pushes the expected RAM
// accesses into a queue, a negedge monitor pops and compares each access.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  csr_address = '0;
    logic        csr_chipselect = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic [13:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        m_clken;
    logic        irq;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        wr;
        logic [13:0] addr;
        logic [31:0] data;
    } acc_t;
    acc_t exp_q[$];

    // RAM model with preload port
    logic [31:0] mem [0:16383];
    logic        pl_en = 1'b0;
    logic [13:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    mem_copy_engine dut (
        .clk(clk), .reset(reset),
        .csr_address(csr_address), .csr_chipselect(csr_chipselect),
        .csr_write(csr_write), .csr_writedata(csr_writedata),
        .csr_readdata(csr_readdata),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata),
        .m_clken(m_clken), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (m_chipselect && m_clken) begin
            if (m_write) mem[m_address] <= m_writedata;
            else         m_readdata <= mem[m_address];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every RAM access must match the head of the expectation queue
    always @(negedge clk) begin : monitor
        acc_t e;
        if (!reset && m_chipselect) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_access actual=wr%0b@%0d expected=none", m_write, m_address);
            end else begin
                e = exp_q.pop_front();
                chk("bus_wr", 32'(m_write), 32'(e.wr));
                chk("bus_addr", 32'(m_address), 32'(e.addr));
                if (e.wr) chk("bus_data", m_writedata, e.data);
                chk("bus_be", 32'(m_byteenable), 32'hF);
            end
        end
    end

    task automatic push_rd(input int a);
        exp_q.push_back({1'b0, 14'(a), 32'h0});
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        exp_q.push_back({1'b1, 14'(a), d});
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = 14'(a); pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // write is taken at the next posedge; returns 1 ns after it
    task automatic csr_wr(input int a, input logic [31:0] d);
        csr_address = 3'(a); csr_writedata = d;
        csr_chipselect = 1'b1; csr_write = 1'b1;
        @(posedge clk); #1;
        csr_chipselect = 1'b0; csr_write = 1'b0;
    endtask

    task automatic csr_rd(input int a, output logic [31:0] d);
        csr_address = 3'(a);
        #1;
        d = csr_readdata;
    endtask

    // counts edges from the last CSR write edge until done is observed
    task automatic wait_done(input int exp_cyc, input string name);
        int k;
        bit busy_ok;
        bit seen;
        k = 1; busy_ok = 1'b1; seen = 1'b0;
        csr_address = 3'd3;
        while (!seen && k < 2000) begin
            @(posedge clk); #1;
            if (csr_readdata[1]) seen = 1'b1;
            else begin
                if (!csr_readdata[0]) busy_ok = 1'b0;
                k++;
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        if (exp_cyc > 0) chk({name, "_latency"}, 32'(k), 32'(exp_cyc));
        chk({name, "_busy_held"}, 32'(busy_ok), 32'd1);
        chk({name, "_busy_clear"}, 32'(csr_readdata[0]), 32'd0);
    endtask

    initial begin : stim
        logic [31:0] rd;

        // reset state
        #3;
        chk("rst_cs", 32'(m_chipselect), 0);
        chk("rst_write", 32'(m_write), 0);
        chk("rst_addr", 32'(m_address), 0);
        chk("rst_wdata", m_writedata, 0);
        chk("rst_be", 32'(m_byteenable), 0);
        chk("rst_clken", 32'(m_clken), 1);
        chk("rst_irq", 32'(irq), 0);
        csr_rd(3, rd); chk("rst_ctrl", rd, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // basic copy of 4 words, 0 -> 100
        for (int i = 0; i < 4; i++) preload(i, 32'hA000_0000 + 32'(i));
        csr_wr(0, 0); csr_wr(1, 100); csr_wr(2, 4);
        for (int i = 0; i < 4; i++) begin
            push_rd(i); push_wr(100 + i, 32'hA000_0000 + 32'(i));
        end
        csr_wr(3, 32'h1);
        wait_done(13, "copy4");
        for (int i = 0; i < 4; i++) chk("copy4_mem", mem[100 + i], 32'hA000_0000 + 32'(i));
        csr_rd(3, rd); chk("copy4_ctrl", rd, 32'h2);
        chk("copy4_q_empty", 32'(exp_q.size()), 0);

        // LEN=0 with interrupt enabled: no RAM access, done next edge
        csr_wr(2, 0);
        csr_wr(3, 32'h9);
        wait_done(1, "len0");
        chk("len0_irq", 32'(irq), 1);
        csr_rd(3, rd); chk("len0_ctrl", rd, 32'hA);
        csr_wr(3, 32'hA);
        csr_rd(3, rd); chk("len0_clr_ctrl", rd, 32'h8);
        chk("len0_clr_irq", 32'(irq), 0);

        // address wrap; overlap propagates the first word forward
        preload(16382, 32'hB000_0000); preload(16383, 32'hB000_0001); preload(0, 32'hB000_0002);
        csr_wr(0, 16382); csr_wr(1, 16383); csr_wr(2, 3);
        push_rd(16382); push_wr(16383, 32'hB000_0000);
        push_rd(16383); push_wr(0, 32'hB000_0000);
        push_rd(0);     push_wr(1, 32'hB000_0000);
        csr_wr(3, 32'h1);
        wait_done(10, "wrap");
        chk("wrap_mem1", mem[1], 32'hB000_0000);
        chk("wrap_q_empty", 32'(exp_q.size()), 0);

        // reset during second word's CAP
        for (int i = 0; i < 3; i++) preload(200 + i, 32'hC000_0000 + 32'(i));
        preload(301, 32'h1111_1111);
        csr_wr(0, 200); csr_wr(1, 300); csr_wr(2, 3);
        push_rd(200); push_wr(300, 32'hC000_0000); push_rd(201);
        csr_wr(3, 32'h1);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_cs", 32'(m_chipselect), 0);
        chk("arst_write", 32'(m_write), 0);
        chk("arst_addr", 32'(m_address), 0);
        chk("arst_wdata", m_writedata, 0);
        chk("arst_be", 32'(m_byteenable), 0);
        csr_rd(3, rd); chk("arst_ctrl", rd, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("arst_mem300", mem[300], 32'hC000_0000);
        chk("arst_mem301", mem[301], 32'h1111_1111);
        chk("arst_q_empty", 32'(exp_q.size()), 0);
        csr_wr(0, 200); csr_wr(1, 300); csr_wr(2, 3);
        for (int i = 0; i < 3; i++) begin
            push_rd(200 + i); push_wr(300 + i, 32'hC000_0000 + 32'(i));
        end
        csr_wr(3, 32'h1);
        wait_done(10, "after_rst");
        chk("after_rst_mem301", mem[301], 32'hC000_0001);
        chk("after_rst_mem302", mem[302], 32'hC000_0002);

        // go and SRC write while busy are ignored
        preload(400, 32'hD000_0000); preload(401, 32'hD000_0001); preload(55, 32'h5555_5555);
        csr_wr(0, 400); csr_wr(1, 500); csr_wr(2, 2);
        push_rd(400); push_wr(500, 32'hD000_0000);
        push_rd(401); push_wr(501, 32'hD000_0001);
        csr_wr(3, 32'h1);
        csr_wr(0, 55);
        csr_wr(3, 32'h1);
        wait_done(5, "busy_ign");
        csr_rd(0, rd); chk("busy_ign_src", rd, 400);
        chk("busy_ign_mem500", mem[500], 32'hD000_0000);
        chk("busy_ign_mem501", mem[501], 32'hD000_0001);
        csr_wr(3, 32'h2);
        repeat (12) @(posedge clk);
        #1;
        csr_rd(3, rd); chk("busy_ign_done_once", rd, 0);
        chk("busy_ign_q_empty", 32'(exp_q.size()), 0);

        // fill request: fills when compiled in, otherwise a plain copy
        for (int i = 0; i < 5; i++) preload(20 + i, 32'hE000_0000 + 32'(i));
        csr_wr(0, 20); csr_wr(4, 32'hDEAD_BEEF); csr_wr(1, 10); csr_wr(2, 5);
`ifdef MEM_COPY_FILL_EN
        for (int i = 0; i < 5; i++) push_wr(10 + i, 32'hDEAD_BEEF);
        csr_wr(3, 32'h5);
        wait_done(6, "fill");
        for (int i = 0; i < 5; i++) chk("fill_mem", mem[10 + i], 32'hDEAD_BEEF);
        csr_rd(4, rd); chk("fill_reg", rd, 32'hDEAD_BEEF);
        csr_rd(3, rd); chk("fill_mode", rd & 32'h4, 32'h4);
`else
        for (int i = 0; i < 5; i++) begin
            push_rd(20 + i); push_wr(10 + i, 32'hE000_0000 + 32'(i));
        end
        csr_wr(3, 32'h5);
        wait_done(16, "nofill");
        for (int i = 0; i < 5; i++) chk("nofill_mem", mem[10 + i], 32'hE000_0000 + 32'(i));
        csr_rd(4, rd); chk("nofill_reg", rd, 0);
        csr_rd(3, rd); chk("nofill_mode", rd & 32'h4, 0);
`endif
        chk("fill_q_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
